// File: rtl/sync_fifo.sv
// Single-clock FIFO with a register-array store, wrapping pointers and an occupancy count.
// rst_n is a synchronous reset that is active when high.
module sync_fifo #(
    parameter int Data_Width = 8,
    parameter int FIFO_Depth = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [Data_Width-1:0]         data_in,
    input  logic                          wr,
    input  logic                          rd,
    output logic [Data_Width-1:0]         data_out,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_Depth):0]   count
);

    localparam int Ptr_W = $clog2(FIFO_Depth);
    localparam int Cnt_W = Ptr_W + 1;

    logic [Data_Width-1:0] mem [FIFO_Depth];
    logic [Ptr_W-1:0]      wr_ptr;
    logic [Ptr_W-1:0]      rd_ptr;
    logic                  wr_ok;
    logic                  rd_ok;

    assign empty = (count == '0);
    assign full  = (count == Cnt_W'(FIFO_Depth));

    // A read frees a slot in the same edge, so a full FIFO still takes a write alongside a read.
    assign wr_ok = wr && (!full || rd);
    assign rd_ok = rd && !empty;

    // The store has no reset; reset only has to block writes.
    always_ff @(posedge clk) begin
        if (!rst_n && wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + Ptr_W'(1);
            end
            if (rd_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + Ptr_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + Cnt_W'(1);
                2'b01:   count <= count - Cnt_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: accepted writes queue their data, and accepted reads
// pop the expected word and compare it with data_out.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [DW-1:0] data_out;
    logic          empty;
    logic          full;
    logic [4:0]    count;

    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_dout = '0;
    int            n_cmp = 0;
    int            n_err = 0;

    sync_fifo #(.Data_Width(DW), .FIFO_Depth(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out),
        .empty    (empty),
        .full     (full),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'(sb.size()));
        check({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
        check({tag, ".full"},  32'(full),  32'(sb.size() == DEPTH));
        check({tag, ".dout"},  32'(data_out), 32'(exp_dout));
    endtask

    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        bit wa, ra;
        wa = w && ((sb.size() != DEPTH) || r);
        ra = r && (sb.size() != 0);
        wr = w;
        rd = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        if (ra) exp_dout = sb.pop_front();
        if (wa) sb.push_back(d);
        check_state(tag);
    endtask

    task automatic do_reset(input logic w, input logic [DW-1:0] d, input int edges);
        rst_n = 1'b1;
        wr = w;
        data_in = d;
        repeat (edges) @(posedge clk);
        #1;
        rst_n = 1'b0;
        wr = 1'b0;
        sb.delete();
        exp_dout = '0;
        check_state("reset");
    endtask

    initial begin
        logic [DW-1:0] last_dout;

        do_reset(1'b0, 8'h00, 2);
        do_reset(1'b1, 8'hFF, 1);
        step(1'b0, 1'b1, 8'h00, "rd_after_rst_wr");

        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'($urandom), "fill");
        check("full_after_fill", 32'(full), 32'd1);
        step(1'b1, 1'b0, 8'h77, "wr_when_full");

        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, "drain");
        last_dout = exp_dout;
        step(1'b0, 1'b1, 8'h00, "rd_when_empty");
        check("dout_hold_empty", 32'(data_out), 32'(last_dout));

        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'($urandom), "wrap_w10");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, "wrap_r10");
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, DW'($urandom), "wrap_w12");
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00, "wrap_r12");
        check("wrap_count_zero", 32'(count), 32'd0);

        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'($urandom), "fill2");
        step(1'b1, 1'b1, 8'hA5, "rdwr_full");
        check("rdwr_full_count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, "drain2");
        check("a5_last", 32'(data_out), 32'hA5);

        last_dout = data_out;
        step(1'b1, 1'b1, 8'h3C, "rdwr_empty");
        check("rdwr_empty_count", 32'(count), 32'd1);
        check("rdwr_empty_dout", 32'(data_out), 32'(last_dout));
        step(1'b0, 1'b1, 8'h00, "rd_3c");
        check("got_3c", 32'(data_out), 32'h3C);

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 1'($urandom), DW'($urandom), "random");
            if (i == 150) do_reset(1'b1, 8'h5A, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-in/first-out buffer for Data_Width-bit words, FIFO_Depth entries deep. It decouples a producer and a consumer that share one clock domain. It provides full/empty flags and an occupancy count for flow control. Storage is a register array indexed by wrapping read/write pointers; all outputs are registered.

## Interface
Parameters:
- Data_Width, 8, width of each stored word in bits.
- FIFO_Depth, 16, number of entries; must be a power of two, ≥ 2.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  synchronous reset, active-high: asserted = 1, sampled on the rising edge of clk. The port keeps the codebase name rst_n.
- data_in  input  Data_Width  word to write.
- wr  input  1  write request.
- rd  input  1  read request.
- data_out  output  Data_Width  registered read data.
- empty  output  1  high when count == 0.
- full  output  1  high when count == FIFO_Depth.
- count  output  $clog2(FIFO_Depth)+1  current occupancy, 0..FIFO_Depth.

## Operation
- Write pointer, read pointer and count are registers. The pointers are $clog2(FIFO_Depth) bits wide and wrap naturally from FIFO_Depth-1 to 0.
- Write accepted = wr && (!full || rd). An accepted write stores data_in at the write pointer, then the write pointer increments.
- Read accepted = rd && !empty. An accepted read loads data_out with the entry at the read pointer, then the read pointer increments.
- Count update:
  - Accepted write only: +1.
  - Accepted read only: −1.
  - Both accepted: unchanged.
  - Neither: unchanged.
- Write while full with no read: ignored. Storage, pointers and count are unchanged.
- Read while empty: ignored. data_out holds its previous value, and pointers and count are unchanged.
- Simultaneous rd and wr:
  - When full: both are accepted, the oldest word is output, and the new word is stored in the freed slot.
  - When empty: only the write is accepted. data_out is not updated.
- empty and full are decoded combinationally from the count register, so both track count with no extra delay.
- data_out changes only on an accepted read or on reset.
- Storage contents are not reset.

## Timing
- Reset: when rst_n is high at a rising edge, the following take effect on that edge:
  - Pointers become 0, count = 0, data_out = 0.
  - empty = 1, full = 0.
  - Reset overrides any rd/wr in the same cycle.
  - Reset mid-operation discards all stored words.
- Write latency: a word written at edge N is readable by a read request sampled at edge N+1.
- Read latency: rd sampled high at edge N (FIFO not empty) puts the word on data_out after edge N. The word is valid through edge N+1 until the next accepted read.
- Flags and count reflect all requests accepted at the most recent edge.
- Order is strictly preserved across pointer wrap-around.

## Test plan
- Reset: hold rst_n=1 for 2 edges with rd=wr=0 → count=0, empty=1, full=0, data_out=0. Assert rst_n with wr=1 → nothing is stored.
- Fill: after reset release, write 16 random bytes on consecutive edges → count steps 1..16, empty drops after the first write, full=1 after the 16th. A 17th write with rd=0 is ignored and count stays 16.
- Drain: then 16 consecutive reads → data_out returns the 16 bytes in write order, count steps 15..0, empty=1 after the last. A 17th read leaves data_out unchanged.
- Wrap-around: write 10 bytes, read 10, write 12, read 12 → all 22 words come back in order, and count returns to 0.
- Simultaneous at full: with the FIFO full, assert rd=wr=1 with data_in=0xA5 → data_out is the oldest word, count stays 16, and 0xA5 emerges last on drain.
- Simultaneous at empty: with the FIFO empty, assert rd=wr=1 with data_in=0x3C → count=1, data_out unchanged. The next read returns 0x3C.
